// File: rtl/beam_seq_pkg.sv
// Shared types, default geometry and width helpers for the beam sequencer.
package beam_seq_pkg;

  // Width of a field that must index n items; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CFG_W   = 16;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_N_MODES = 4;
  localparam int DEF_DWELL_W = 16;

  localparam int MODE_W         = $clog2(DEF_N_MODES);
  localparam int IDX_W          = $clog2(DEF_DEPTH);
  localparam int BYTES_PER_WORD = DEF_CFG_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/beam_seq_if.sv
// Host byte interface plus playback outputs of the beam sequencer.
interface beam_seq_if
  import beam_seq_pkg::*;
#(
  parameter int CFG_W   = DEF_CFG_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int N_MODES = DEF_N_MODES,
  parameter int DWELL_W = DEF_DWELL_W
) ();
  localparam int BANK_W = width_of(N_MODES);
  localparam int SLOT_W = width_of(DEPTH);

  logic [BANK_W-1:0]  mode;
  logic               wr;
  logic               stb;
  logic [7:0]         dato;
  logic               seq_en;
  logic               loop;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [CFG_W-1:0]   cfg_out;
  logic               cfg_valid;
  logic [SLOT_W-1:0]  step_idx;
  logic               busy;
  logic               done;

  modport master (
    output mode, wr, stb, dato, seq_en, loop, stop, dwell,
    input  cfg_out, cfg_valid, step_idx, busy, done
  );

  modport slave (
    input  mode, wr, stb, dato, seq_en, loop, stop, dwell,
    output cfg_out, cfg_valid, step_idx, busy, done
  );
endinterface

// File: rtl/beam_seq_ram.sv
// Table storage: one write port, one registered read port, address {bank, idx}.
module beam_seq_ram #(
  parameter int CFG_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [CFG_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [CFG_W-1:0]  rdata_o
);
  logic [CFG_W-1:0] mem_q [2**ADDR_W];
  logic [CFG_W-1:0] rdata_q;

  // Write committed words and register the addressed word on a read.
  // NOTE: the array has no reset so it maps onto RAM macros; playback only
  // reads entries below len, which are always written first.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/beam_seq_engine.sv
// Beam-configuration sequencer: host byte assembler, per-bank length
// registers and the playback FSM around a banked table RAM.
module beam_seq_engine
  import beam_seq_pkg::*;
#(
  parameter int CFG_W   = DEF_CFG_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int N_MODES = DEF_N_MODES,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input logic       clk,
  input logic       rst_n,
  beam_seq_if.slave bus
);
  localparam int BANK_W = width_of(N_MODES);
  localparam int SLOT_W = width_of(DEPTH);
  localparam int NBYTES = CFG_W / 8;
  localparam int BCNT_W = width_of(NBYTES);
  localparam int ADDR_W = BANK_W + SLOT_W;

  // Write-side state.
  logic              wr_q, sess_q;
  logic [BANK_W-1:0] wbank_q;
  logic [SLOT_W:0]   ptr_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [CFG_W-1:0]  asm_q;
  logic [SLOT_W:0]   len_q [N_MODES];

  // Playback state and registered outputs.
  seq_state_e         state_q;
  logic [BANK_W-1:0]  pbank_q;
  logic               loop_q, pend_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic [SLOT_W-1:0]  idx_q;
  logic [CFG_W-1:0]   cfg_out_q;
  logic               cfg_valid_q, done_q;
  logic [SLOT_W-1:0]  step_idx_q;

  logic               busy, wr_rise, byte_ok, commit, we, more;
  logic [BANK_W-1:0]  cur_bank;
  logic [SLOT_W:0]    cur_ptr, sel_len, cur_len;
  logic [BCNT_W-1:0]  cur_bcnt;
  logic [CFG_W-1:0]   asm_word, rd_data;
  logic [DWELL_W-1:0] dwell_eff;
  logic [SLOT_W-1:0]  nxt_idx;

  assign busy    = (state_q != ST_IDLE);
  assign wr_rise = bus.wr & ~wr_q & ~busy;
  // A byte on the rising-edge cycle belongs to the new session.
  assign byte_ok  = bus.wr & bus.stb & ~busy & (sess_q | wr_rise);
  assign cur_bank = wr_rise ? bus.mode : wbank_q;
  assign cur_ptr  = wr_rise ? '0 : ptr_q;
  assign cur_bcnt = wr_rise ? '0 : bcnt_q;
  assign commit   = byte_ok && (cur_bcnt == BCNT_W'(NBYTES - 1));
  assign we       = commit && (cur_ptr < (SLOT_W + 1)'(DEPTH));

  assign sel_len   = len_q[bus.mode];
  assign cur_len   = len_q[pbank_q];
  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign more      = (({1'b0, idx_q} + 1'b1) < cur_len);
  assign nxt_idx   = more ? idx_q + 1'b1 : '0;

  // Drop the incoming byte into its lane of the word being assembled.
  // NOTE: the default assignment first keeps this block purely combinational.
  always_comb begin
    asm_word = asm_q;
    asm_word[{cur_bcnt, 3'b000} +: 8] = bus.dato;
  end

  beam_seq_ram #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({cur_bank, cur_ptr[SLOT_W-1:0]}),
    .wdata_i (asm_word),
    .re_i    (state_q == ST_LOAD),
    .raddr_i ({pbank_q, idx_q}),
    .rdata_o (rd_data)
  );

  // Write sessions: open on wr rise, assemble bytes, commit words, track len.
  // NOTE: non-blocking assignments make every register see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      sess_q  <= 1'b0;
      wbank_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      for (int b = 0; b < N_MODES; b++) len_q[b] <= '0;
    end else begin
      wr_q <= bus.wr;
      if (wr_rise) begin
        sess_q  <= 1'b1;
        wbank_q <= bus.mode;
        ptr_q   <= '0;
        bcnt_q  <= '0;
      end
      if (!bus.wr) begin
        sess_q <= 1'b0;
        bcnt_q <= '0;
      end
      if (byte_ok) begin
        asm_q  <= asm_word;
        bcnt_q <= commit ? '0 : cur_bcnt + 1'b1;
        if (we) begin
          ptr_q           <= cur_ptr + 1'b1;
          len_q[cur_bank] <= cur_ptr + 1'b1;
        end
      end
    end
  end

  // Playback FSM with registered outputs; stop overrides every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pbank_q     <= '0;
      loop_q      <= 1'b0;
      pend_q      <= 1'b0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      cfg_out_q   <= '0;
      cfg_valid_q <= 1'b0;
      step_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (bus.stop) begin
        state_q <= ST_IDLE;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (bus.seq_en) begin
            pbank_q <= bus.mode;
            loop_q  <= bus.loop;
            dwell_q <= dwell_eff;
            idx_q   <= '0;
            state_q <= (sel_len == '0) ? ST_FINISH : ST_LOAD;
          end
          ST_LOAD: begin
            pend_q  <= 1'b1;
            cnt_q   <= dwell_q - 1'b1;
            state_q <= ST_DWELL;
          end
          ST_DWELL: begin
            // The word read during LOAD reaches cfg_out on the first DWELL edge.
            if (pend_q) begin
              cfg_out_q   <= rd_data;
              step_idx_q  <= idx_q;
              cfg_valid_q <= 1'b1;
              pend_q      <= 1'b0;
            end
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (more || loop_q) begin
              idx_q   <= nxt_idx;
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_out   = cfg_out_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.step_idx  = step_idx_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
endmodule
